// File: rtl/ysyx_22050598_idu_stage_pkg.sv
// Shared decode constants for the IDU stage: instruction classes, major
// opcodes and the func3/func7 values the legality checks look at.
package ysyx_22050598_idu_stage_pkg;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_SYSTEM  = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_MULDIV  = 4'd11,
    CLS_ILLEGAL = 4'd15
  } inst_class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_ALUIW  = 7'b0011011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALUR   = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_ALURW  = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_LD_SD   = 3'b011;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_LOAD_X  = 3'b111;
  localparam logic [2:0] F3_BR_X0   = 3'b010;
  localparam logic [2:0] F3_BR_X1   = 3'b011;

endpackage

// File: rtl/ysyx_22050598_idu_dec_core.sv
// Purely combinational RV32/RV64 (+optional M) decoder: class, immediate,
// register-write enable, word-op flag and illegal-instruction detection.
module ysyx_22050598_idu_dec_core
  import ysyx_22050598_idu_stage_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]     inst_i,
  output logic [3:0]      class_o,
  output logic [XLEN-1:0] imm_o,
  output logic            w_reg_en_o,
  output logic            is_word_o,
  output logic            illegal_o
);

  localparam bit IS_RV32 = (XLEN == 32);

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        f3_is_shift;

  assign opcode      = inst_i[6:0];
  assign func3       = inst_i[14:12];
  assign func7       = inst_i[31:25];
  assign f3_is_shift = (func3 == F3_SLL) || (func3 == F3_SRL_SRA);

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  inst_class_e cls;
  logic [31:0] imm32;
  logic        wen, word, bad;

  always_comb begin
    cls   = CLS_ILLEGAL;
    imm32 = '0;
    wen   = 1'b0;
    word  = 1'b0;
    bad   = (inst_i[1:0] != 2'b11);
    case (opcode)
      OPC_ALUR, OPC_ALURW: begin
        wen  = 1'b1;
        word = (opcode == OPC_ALURW);
        if (word && IS_RV32) bad = 1'b1;
        if (func7 == F7_MULDIV) begin
          cls = CLS_MULDIV;
          if (!EN_M) bad = 1'b1;
        end else if (func7 == F7_BASE) begin
          cls = CLS_ALU_R;
        end else if (func7 == F7_ALT && (func3 == F3_ADD_SUB || func3 == F3_SRL_SRA)) begin
          cls = CLS_ALU_R;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_ALUI: begin
        cls   = CLS_ALU_I;
        imm32 = imm_i;
        wen   = 1'b1;
        if (f3_is_shift && inst_i[25] && IS_RV32) bad = 1'b1;
      end
      OPC_ALUIW: begin
        cls   = CLS_ALU_I;
        imm32 = imm_i;
        wen   = 1'b1;
        word  = 1'b1;
        if (IS_RV32 || (f3_is_shift && inst_i[25])) bad = 1'b1;
      end
      OPC_LOAD: begin
        cls   = CLS_LOAD;
        imm32 = imm_i;
        wen   = 1'b1;
        if (func3 == F3_LOAD_X) bad = 1'b1;
        if (IS_RV32 && (func3 == F3_LD_SD || func3 == F3_LWU)) bad = 1'b1;
      end
      OPC_STORE: begin
        cls   = CLS_STORE;
        imm32 = imm_s;
        if (func3[2] || (IS_RV32 && func3 == F3_LD_SD)) bad = 1'b1;
      end
      OPC_BRANCH: begin
        cls   = CLS_BRANCH;
        imm32 = imm_b;
        if (func3 == F3_BR_X0 || func3 == F3_BR_X1) bad = 1'b1;
      end
      OPC_JAL: begin
        cls   = CLS_JAL;
        imm32 = imm_j;
        wen   = 1'b1;
      end
      OPC_JALR: begin
        cls   = CLS_JALR;
        imm32 = imm_i;
        wen   = 1'b1;
        if (func3 != F3_ADD_SUB) bad = 1'b1;
      end
      OPC_LUI: begin
        cls   = CLS_LUI;
        imm32 = imm_u;
        wen   = 1'b1;
      end
      OPC_AUIPC: begin
        cls   = CLS_AUIPC;
        imm32 = imm_u;
        wen   = 1'b1;
      end
      OPC_SYSTEM: begin
        // Only the CSR forms (func3 != 0) write rd; ecall/ebreak/mret do not.
        cls   = CLS_SYSTEM;
        imm32 = imm_i;
        wen   = (func3 != 3'b000);
      end
      OPC_FENCE: begin
        cls   = CLS_FENCE;
        imm32 = imm_i;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      cls   = CLS_ILLEGAL;
      imm32 = '0;
      wen   = 1'b0;
      word  = 1'b0;
    end
  end

  assign class_o    = cls;
  assign imm_o      = XLEN'($signed(imm32));
  assign w_reg_en_o = wen;
  assign is_word_o  = word;
  assign illegal_o  = bad;

endmodule

// File: rtl/ysyx_22050598_idu_stage.sv
// Decode stage: DEPTH-entry {pc, inst} queue feeding a registered
// valid/ready output slot holding the decoded queue head.
module ysyx_22050598_idu_stage
  import ysyx_22050598_idu_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [31:0]     if_inst_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_inst_o,
  output logic [3:0]      id_class_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [4:0]      id_rs1_idx_o,
  output logic [4:0]      id_rs2_idx_o,
  output logic [4:0]      id_rd_idx_o,
  output logic            id_w_reg_en_o,
  output logic            id_is_word_o,
  output logic            id_illegal_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem_pc_q   [DEPTH];
  logic [XLEN-1:0] mem_pc_d   [DEPTH];
  logic [31:0]     mem_inst_q [DEPTH];
  logic [31:0]     mem_inst_d [DEPTH];

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [31:0]     inst_q, inst_d;
  logic [3:0]      class_q, class_d;
  logic            w_reg_en_q, w_reg_en_d, is_word_q, is_word_d, illegal_q, illegal_d;

  logic            push, load;
  logic [3:0]      dec_class;
  logic [XLEN-1:0] dec_imm;
  logic            dec_w_reg_en, dec_is_word, dec_illegal;

  assign if_ready_o = (count_q != CW'(DEPTH));
  assign push       = if_valid_i & if_ready_o;
  assign load       = (count_q != '0) & (~valid_q | id_ready_i);

  ysyx_22050598_idu_dec_core #(
    .XLEN (XLEN),
    .EN_M (EN_M)
  ) u_dec_core (
    .inst_i     (mem_inst_q[rd_ptr_q]),
    .class_o    (dec_class),
    .imm_o      (dec_imm),
    .w_reg_en_o (dec_w_reg_en),
    .is_word_o  (dec_is_word),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    if (push && !flush_i) begin
      mem_pc_d[wr_ptr_q]   = if_pc_i;
      mem_inst_d[wr_ptr_q] = if_inst_i;
    end
  end

  // Flush wins over push/pop; data outputs keep their last values on flush and drain.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    class_d    = class_q;
    imm_d      = imm_q;
    w_reg_en_d = w_reg_en_q;
    is_word_d  = is_word_q;
    illegal_d  = illegal_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      valid_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (load) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        valid_d    = 1'b1;
        pc_d       = mem_pc_q[rd_ptr_q];
        inst_d     = mem_inst_q[rd_ptr_q];
        class_d    = dec_class;
        imm_d      = dec_imm;
        w_reg_en_d = dec_w_reg_en;
        is_word_d  = dec_is_word;
        illegal_d  = dec_illegal;
      end else if (id_ready_i) begin
        valid_d = 1'b0;
      end
      count_d = count_q + CW'(push) - CW'(load);
    end
  end

  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_inst_q <= mem_inst_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      class_q    <= '0;
      imm_q      <= '0;
      w_reg_en_q <= 1'b0;
      is_word_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      class_q    <= class_d;
      imm_q      <= imm_d;
      w_reg_en_q <= w_reg_en_d;
      is_word_q  <= is_word_d;
      illegal_q  <= illegal_d;
    end
  end

  assign id_valid_o    = valid_q;
  assign id_pc_o       = pc_q;
  assign id_inst_o     = inst_q;
  assign id_class_o    = class_q;
  assign id_imm_o      = imm_q;
  assign id_rs1_idx_o  = inst_q[19:15];
  assign id_rs2_idx_o  = inst_q[24:20];
  assign id_rd_idx_o   = inst_q[11:7];
  assign id_w_reg_en_o = w_reg_en_q;
  assign id_is_word_o  = is_word_q;
  assign id_illegal_o  = illegal_q;

endmodule

// File: tb/tb_ysyx_22050598_idu_stage.sv
// Self-checking bench: an RV64+M and an RV32 (no M) instance share one
// stimulus stream and are compared against a queue-based reference model.
module tb_ysyx_22050598_idu_stage;

  localparam int DEPTH = 2;

  typedef struct {
    logic [3:0]  cls;
    logic [63:0] imm;
    logic        wen;
    logic        word;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        if_valid_i = 1'b0;
  logic [63:0] if_pc_i = '0;
  logic [31:0] if_inst_i = '0;
  logic        id_ready_i = 1'b0;

  logic        o64_if_ready, o64_valid, o64_wen, o64_word, o64_ill;
  logic [63:0] o64_pc, o64_imm;
  logic [31:0] o64_inst;
  logic [3:0]  o64_class;
  logic [4:0]  o64_rs1, o64_rs2, o64_rd;

  logic        o32_if_ready, o32_valid, o32_wen, o32_word, o32_ill;
  logic [31:0] o32_pc, o32_imm, o32_inst;
  logic [3:0]  o32_class;
  logic [4:0]  o32_rs1, o32_rs2, o32_rd;

  int tests_run = 0;
  int tests_failed = 0;

  item_t mq[$];
  logic  m_valid;
  item_t m_slot;
  dec_t  m_d64, m_d32;

  always #5 clk = ~clk;

  ysyx_22050598_idu_stage #(.XLEN(64), .DEPTH(DEPTH), .EN_M(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(o64_if_ready), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .id_valid_o(o64_valid), .id_ready_i(id_ready_i), .id_pc_o(o64_pc), .id_inst_o(o64_inst),
    .id_class_o(o64_class), .id_imm_o(o64_imm), .id_rs1_idx_o(o64_rs1), .id_rs2_idx_o(o64_rs2),
    .id_rd_idx_o(o64_rd), .id_w_reg_en_o(o64_wen), .id_is_word_o(o64_word), .id_illegal_o(o64_ill)
  );

  ysyx_22050598_idu_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b0)) dut32 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(o32_if_ready), .if_pc_i(if_pc_i[31:0]), .if_inst_i(if_inst_i),
    .id_valid_o(o32_valid), .id_ready_i(id_ready_i), .id_pc_o(o32_pc), .id_inst_o(o32_inst),
    .id_class_o(o32_class), .id_imm_o(o32_imm), .id_rs1_idx_o(o32_rs1), .id_rs2_idx_o(o32_rs2),
    .id_rd_idx_o(o32_rd), .id_w_reg_en_o(o32_wen), .id_is_word_o(o32_word), .id_illegal_o(o32_ill)
  );

  // Reference decoder written directly from the ISA rules, at 64-bit width.
  function automatic dec_t ref_decode(input logic [31:0] i, input int xlen, input bit en_m);
    dec_t d;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic [63:0] ii = {{52{i[31]}}, i[31:20]};
    logic [63:0] si = {{52{i[31]}}, i[31:25], i[11:7]};
    logic [63:0] bi = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [63:0] ui = {{32{i[31]}}, i[31:12], 12'b0};
    logic [63:0] ji = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    bit shift = (f3 == 3'd1) || (f3 == 3'd5);
    bit bad = (i[1:0] != 2'b11);
    d = '{cls: 4'd0, imm: 64'd0, wen: 1'b0, word: 1'b0, ill: 1'b0};
    case (op)
      7'h33, 7'h3B: begin
        d.wen = 1; d.word = (op == 7'h3B);
        if (op == 7'h3B && xlen == 32) bad = 1;
        if (f7 == 7'b0000001) begin d.cls = 11; if (!en_m) bad = 1; end
        else if (f7 == 7'b0000000) d.cls = 0;
        else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) d.cls = 0;
        else bad = 1;
      end
      7'h13: begin d.cls = 1; d.imm = ii; d.wen = 1; if (shift && i[25] && xlen == 32) bad = 1; end
      7'h1B: begin d.cls = 1; d.imm = ii; d.wen = 1; d.word = 1; if (xlen == 32 || (shift && i[25])) bad = 1; end
      7'h03: begin d.cls = 2; d.imm = ii; d.wen = 1; if (f3 == 7 || (xlen == 32 && (f3 == 3 || f3 == 6))) bad = 1; end
      7'h23: begin d.cls = 3; d.imm = si; if (f3 >= 4 || (xlen == 32 && f3 == 3)) bad = 1; end
      7'h63: begin d.cls = 4; d.imm = bi; if (f3 == 2 || f3 == 3) bad = 1; end
      7'h6F: begin d.cls = 5; d.imm = ji; d.wen = 1; end
      7'h67: begin d.cls = 6; d.imm = ii; d.wen = 1; if (f3 != 0) bad = 1; end
      7'h37: begin d.cls = 7; d.imm = ui; d.wen = 1; end
      7'h17: begin d.cls = 8; d.imm = ui; d.wen = 1; end
      7'h73: begin d.cls = 9; d.imm = ii; d.wen = (f3 != 0); end
      7'h0F: begin d.cls = 10; d.imm = ii; end
      default: bad = 1;
    endcase
    if (bad) d = '{cls: 4'd15, imm: 64'd0, wen: 1'b0, word: 1'b0, ill: 1'b1};
    if (xlen == 32) d.imm = {32'd0, d.imm[31:0]};
    return d;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] opcs [13] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23, 7'h63,
                              7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 14);
    if (k < 13) r[6:0] = opcs[k];
    case ($urandom_range(0, 4))
      0: r[31:25] = 7'b0000000;
      1: r[31:25] = 7'b0100000;
      2: r[31:25] = 7'b0000001;
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_slot = '{pc: 64'd0, inst: 32'd0};
    m_d64 = '{cls: 4'd0, imm: 64'd0, wen: 1'b0, word: 1'b0, ill: 1'b0};
    m_d32 = m_d64;
  endtask

  // Drives one cycle of inputs, advances the model at the edge, samples 1ns later.
  task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    bit push, load;
    item_t it;
    @(negedge clk);
    if_valid_i = v; if_pc_i = pc; if_inst_i = inst; id_ready_i = rdy; flush_i = fl;
    @(posedge clk);
    push = v && (mq.size() < DEPTH);
    load = (mq.size() > 0) && (!m_valid || rdy);
    if (fl) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      if (load) begin
        it = mq.pop_front();
        m_valid = 1'b1;
        m_slot = it;
        m_d64 = ref_decode(it.inst, 64, 1'b1);
        m_d32 = ref_decode(it.inst, 32, 1'b0);
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (push) mq.push_back('{pc: pc, inst: inst});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #22;
    rst = 1'b0;
    #1;
    tests_run++;
    if (o64_valid !== 1'b0 || o32_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_valid got=%b/%b exp=0/0", o64_valid, o32_valid);
    end
    tests_run++;
    if (o64_if_ready !== 1'b1 || o32_if_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_if_ready got=%b/%b exp=1/1", o64_if_ready, o32_if_ready);
    end
    tests_run++;
    if ({o64_pc, o64_inst, o64_class, o64_imm, o64_wen, o64_word, o64_ill} !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_data64 pc=%h inst=%h class=%0d imm=%h exp=all zero",
                               o64_pc, o64_inst, o64_class, o64_imm);
    end
  endtask

  task automatic test_decode_directed();
    // addi x1,x0,5 ; also checks the one-cycle decode latency
    cycle(1'b1, 64'h1000, 32'h00500093, 1'b1, 1'b0);
    tests_run++;
    if (o64_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL latency_early got=%b exp=0", o64_valid);
    end
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (o64_valid !== 1'b1 || o64_pc !== 64'h1000) begin
      tests_failed++; $display("[TB] FAIL addi_valid got=%b pc=%h exp=1 pc=1000", o64_valid, o64_pc);
    end
    tests_run++;
    if ({o64_class, o64_imm, o64_rd, o64_wen, o64_ill} !== {4'd1, 64'd5, 5'd1, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL addi_fields class=%0d imm=%h rd=%0d wen=%b ill=%b exp=1 5 1 1 0",
                               o64_class, o64_imm, o64_rd, o64_wen, o64_ill);
    end
    // lui x2,0x80000
    cycle(1'b1, 64'h1004, 32'h80000137, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({o64_valid, o64_class, o64_imm, o64_rd} !== {1'b1, 4'd7, 64'hFFFFFFFF80000000, 5'd2}) begin
      tests_failed++; $display("[TB] FAIL lui64 valid=%b class=%0d imm=%h rd=%0d exp=1 7 ffffffff80000000 2",
                               o64_valid, o64_class, o64_imm, o64_rd);
    end
    tests_run++;
    if ({o32_class, o32_imm} !== {4'd7, 32'h80000000}) begin
      tests_failed++; $display("[TB] FAIL lui32 class=%0d imm=%h exp=7 80000000", o32_class, o32_imm);
    end
    // slliw with inst[25]=1
    cycle(1'b1, 64'h1008, 32'h0200109B, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({o64_class, o64_ill, o64_wen, o64_imm} !== {4'd15, 1'b1, 1'b0, 64'd0}) begin
      tests_failed++; $display("[TB] FAIL slliw_illegal class=%0d ill=%b wen=%b imm=%h exp=15 1 0 0",
                               o64_class, o64_ill, o64_wen, o64_imm);
    end
    // addiw x1,x0,0: legal word op on RV64, illegal on RV32
    cycle(1'b1, 64'h100C, 32'h0000009B, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({o64_class, o64_word, o64_ill} !== {4'd1, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL addiw64 class=%0d word=%b ill=%b exp=1 1 0", o64_class, o64_word, o64_ill);
    end
    tests_run++;
    if ({o32_class, o32_ill, o32_word} !== {4'd15, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL addiw32 class=%0d ill=%b word=%b exp=15 1 0", o32_class, o32_ill, o32_word);
    end
    // mul x3,x1,x2: MULDIV with M, illegal without
    cycle(1'b1, 64'h1010, 32'h022081B3, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({o64_class, o64_rd, o64_rs1, o64_rs2, o64_wen} !== {4'd11, 5'd3, 5'd1, 5'd2, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL mul64 class=%0d rd=%0d rs1=%0d rs2=%0d wen=%b exp=11 3 1 2 1",
                               o64_class, o64_rd, o64_rs1, o64_rs2, o64_wen);
    end
    tests_run++;
    if ({o32_class, o32_ill} !== {4'd15, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL mul32_noM class=%0d ill=%b exp=15 1", o32_class, o32_ill);
    end
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs [4] = '{64'h2000, 64'h2004, 64'h2008, 64'h200C};
    for (int k = 0; k < 4; k++) cycle(1'b1, pcs[k], 32'h00100013 + (k << 7), 1'b0, 1'b0);
    tests_run++;
    if (o64_if_ready !== 1'b0 || o32_if_ready !== 1'b0 || o64_valid !== 1'b1 || o64_pc !== 64'h2000) begin
      tests_failed++; $display("[TB] FAIL full_hold if_ready=%b/%b valid=%b pc=%h exp=0/0 1 2000",
                               o64_if_ready, o32_if_ready, o64_valid, o64_pc);
    end
    for (int k = 1; k < 3; k++) begin
      cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      tests_run++;
      if (o64_valid !== 1'b1 || o64_pc !== pcs[k] || o64_rd !== 5'(k)) begin
        tests_failed++; $display("[TB] FAIL drain_order k=%0d valid=%b pc=%h rd=%0d exp=1 %h %0d",
                                 k, o64_valid, o64_pc, o64_rd, pcs[k], k);
      end
    end
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (o64_valid !== 1'b0 || o64_pc !== 64'h2008) begin
      tests_failed++; $display("[TB] FAIL drain_empty valid=%b pc=%h exp=0 2008 (held)", o64_valid, o64_pc);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 64'h3000, 32'h00000013, 1'b0, 1'b0);
    cycle(1'b1, 64'h3004, 32'h00000013, 1'b0, 1'b0);
    cycle(1'b1, 64'h3008, 32'h00000013, 1'b0, 1'b0);
    cycle(1'b1, 64'h300C, 32'h00000013, 1'b0, 1'b1);
    tests_run++;
    if (o64_valid !== 1'b0 || o64_if_ready !== 1'b1 || o32_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL flush_full valid=%b if_ready=%b valid32=%b exp=0 1 0",
                               o64_valid, o64_if_ready, o32_valid);
    end
    cycle(1'b1, 64'h3010, 32'h00000013, 1'b1, 1'b1);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (o64_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL flush_drops_push valid=%b exp=0", o64_valid);
    end
    cycle(1'b1, 64'h3014, 32'h00A00113, 1'b1, 1'b0);
    tests_run++;
    if (o64_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL post_flush_early valid=%b exp=0", o64_valid);
    end
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (o64_valid !== 1'b1 || o64_pc !== 64'h3014 || o64_imm !== 64'd10) begin
      tests_failed++; $display("[TB] FAIL post_flush_push valid=%b pc=%h imm=%h exp=1 3014 a",
                               o64_valid, o64_pc, o64_imm);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [63:0] pc = {$urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, pc, gen_inst(), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      tests_run++;
      if (o64_if_ready !== (mq.size() != DEPTH) || o32_if_ready !== (mq.size() != DEPTH)) begin
        tests_failed++; $display("[TB] FAIL rand_if_ready n=%0d got=%b/%b exp=%b", n, o64_if_ready, o32_if_ready, mq.size() != DEPTH);
      end
      tests_run++;
      if (o64_valid !== m_valid || o32_valid !== m_valid) begin
        tests_failed++; $display("[TB] FAIL rand_valid n=%0d got=%b/%b exp=%b", n, o64_valid, o32_valid, m_valid);
      end
      tests_run++;
      if (o64_pc !== m_slot.pc || o64_inst !== m_slot.inst || o32_pc !== m_slot.pc[31:0]) begin
        tests_failed++; $display("[TB] FAIL rand_pc_inst n=%0d pc=%h inst=%h pc32=%h exp=%h %h", n, o64_pc, o64_inst, o32_pc, m_slot.pc, m_slot.inst);
      end
      tests_run++;
      if ({o64_rs1, o64_rs2, o64_rd} !== {m_slot.inst[19:15], m_slot.inst[24:20], m_slot.inst[11:7]}) begin
        tests_failed++; $display("[TB] FAIL rand_idx n=%0d got=%0d %0d %0d inst=%h", n, o64_rs1, o64_rs2, o64_rd, m_slot.inst);
      end
      tests_run++;
      if ({o64_class, o64_imm, o64_wen, o64_word, o64_ill} !== {m_d64.cls, m_d64.imm, m_d64.wen, m_d64.word, m_d64.ill}) begin
        tests_failed++; $display("[TB] FAIL rand_dec64 n=%0d inst=%h got=%0d %h %b%b%b exp=%0d %h %b%b%b", n, m_slot.inst,
                                 o64_class, o64_imm, o64_wen, o64_word, o64_ill, m_d64.cls, m_d64.imm, m_d64.wen, m_d64.word, m_d64.ill);
      end
      tests_run++;
      if ({o32_class, o32_imm, o32_wen, o32_word, o32_ill} !== {m_d32.cls, m_d32.imm[31:0], m_d32.wen, m_d32.word, m_d32.ill}) begin
        tests_failed++; $display("[TB] FAIL rand_dec32 n=%0d inst=%h got=%0d %h %b%b%b exp=%0d %h %b%b%b", n, m_slot.inst,
                                 o32_class, o32_imm, o32_wen, o32_word, o32_ill, m_d32.cls, m_d32.imm[31:0], m_d32.wen, m_d32.word, m_d32.ill);
      end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 64'h4000, 32'hFFF00093, 1'b0, 1'b0);
    cycle(1'b1, 64'h4004, 32'h00000013, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({o64_valid, o64_pc, o64_inst, o64_class, o64_imm, o64_wen, o64_ill, o64_rd} !== '0 || o64_if_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_mid valid=%b pc=%h inst=%h imm=%h if_ready=%b exp=all zero, if_ready=1",
                               o64_valid, o64_pc, o64_inst, o64_imm, o64_if_ready);
    end
    if_valid_i = 1'b0; id_ready_i = 1'b0; flush_i = 1'b0;
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_midstream();
    cycle(1'b1, 64'h5000, 32'h00500093, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (o64_valid !== 1'b1 || o64_pc !== 64'h5000 || o64_class !== 4'd1) begin
      tests_failed++; $display("[TB] FAIL after_reset_push valid=%b pc=%h class=%0d exp=1 5000 1", o64_valid, o64_pc, o64_class);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
